// File: rtl/raybox_fx_pkg.sv
// ---------------------------------------------------------------------------
// raybox_fx_pkg
// Shared constants and types for the Q12.12 fixed-point datapath.
//   FX_WIDTH       default mantissa width
//   LZC_CNT_W      width of a leading-zero / shift count (0..127)
//   DENORM_STAGES  number of conditional-shift stages in denorm_shift
//   DENORM_CNT_W   width of the clamped shift count carried down the pipe
//   DENORM_SHIFTS  shift amount of each stage, first stage in the top slot
//   denorm_beat_t  one in-flight beat {data, cnt, guard, sticky}
// ---------------------------------------------------------------------------
package raybox_fx_pkg;

    localparam int FX_WIDTH      = 24;
    localparam int LZC_CNT_W     = 7;
    localparam int DENORM_STAGES = 5;
    localparam int DENORM_CNT_W  = 6;
    localparam int FX_MAX_W      = 32;

    // Slot DENORM_STAGES-1 holds the first stage's shift (16).
    localparam logic [DENORM_STAGES-1:0][4:0] DENORM_SHIFTS =
        {5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    typedef struct packed {
        logic [FX_WIDTH-1:0]     data;
        logic [DENORM_CNT_W-1:0] cnt;
        logic                    guard;
        logic                    sticky;
    } denorm_beat_t;

    // Shift amount of pipeline stage k, k = 0 being the first shift stage.
    function automatic int denorm_shift_amt(input int k);
        return int'(DENORM_SHIFTS[DENORM_STAGES-1-k]);
    endfunction

    // Mask with the n least significant bits set (n <= 0 gives zero).
    function automatic logic [FX_MAX_W-1:0] low_ones(input int n);
        logic [FX_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < FX_MAX_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/denorm_stage.sv
// ---------------------------------------------------------------------------
// denorm_stage
// One register slice of the de-normalizing log shifter. Shifts the incoming
// beat right by SHIFT when the matching count bit is set, folding the bits
// that fall off into guard/sticky, and registers the result.
//   clk, reset                 clock, synchronous active-high reset
//   up_valid_i / up_ready_o    upstream handshake
//   up_data_i, up_cnt_i,
//   up_guard_i, up_sticky_i    incoming beat
//   dn_valid_o / dn_ready_i    downstream handshake
//   dn_data_o, dn_cnt_o,
//   dn_guard_o, dn_sticky_o    registered beat
// ---------------------------------------------------------------------------
module denorm_stage
    import raybox_fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up_valid_i,
    output logic                    up_ready_o,
    input  logic [WIDTH-1:0]        up_data_i,
    input  logic [DENORM_CNT_W-1:0] up_cnt_i,
    input  logic                    up_guard_i,
    input  logic                    up_sticky_i,
    output logic                    dn_valid_o,
    input  logic                    dn_ready_i,
    output logic [WIDTH-1:0]        dn_data_o,
    output logic [DENORM_CNT_W-1:0] dn_cnt_o,
    output logic                    dn_guard_o,
    output logic                    dn_sticky_o
);

    localparam logic [DENORM_CNT_W-1:0] SHIFT_BIT = DENORM_CNT_W'(SHIFT);

    // Masks are built from full-width constants so that stages whose shift
    // exceeds WIDTH elaborate cleanly; their count bit is never set.
    localparam logic [FX_MAX_W-1:0] GUARD_M32  = low_ones(SHIFT) ^ low_ones(SHIFT - 1);
    localparam logic [FX_MAX_W-1:0] STICKY_M32 = low_ones(SHIFT - 1);
    localparam logic [WIDTH-1:0]    GUARD_MASK  = GUARD_M32[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    STICKY_MASK = STICKY_M32[WIDTH-1:0];

    logic                    valid_q;
    logic [WIDTH-1:0]        data_q,   data_d;
    logic [DENORM_CNT_W-1:0] cnt_q,    cnt_d;
    logic                    guard_q,  guard_d;
    logic                    sticky_q, sticky_d;
    logic                    do_shift;

    assign do_shift   = |(up_cnt_i & SHIFT_BIT);
    assign up_ready_o = ~valid_q | dn_ready_i;

    always_comb begin
        data_d   = up_data_i;
        cnt_d    = up_cnt_i & ~SHIFT_BIT;
        guard_d  = up_guard_i;
        sticky_d = up_sticky_i;
        if (do_shift) begin
            data_d   = up_data_i >> SHIFT;
            guard_d  = |(up_data_i & GUARD_MASK);
            sticky_d = up_sticky_i | up_guard_i | (|(up_data_i & STICKY_MASK));
        end
    end

    // ---- register slice ----
    // Payload only moves with a valid beat so an idle output keeps its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (up_ready_o) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                data_q   <= data_d;
                cnt_q    <= cnt_d;
                guard_q  <= guard_d;
                sticky_q <= sticky_d;
            end
        end
    end

    assign dn_valid_o  = valid_q;
    assign dn_data_o   = data_q;
    assign dn_cnt_o    = cnt_q;
    assign dn_guard_o  = guard_q;
    assign dn_sticky_o = sticky_q;

endmodule

// File: rtl/denorm_shift.sv
// ---------------------------------------------------------------------------
// denorm_shift
// Pipelined de-normalizer: shifts a left-justified mantissa right by a count
// (the inverse of the leading-zero counter) and reports guard and sticky bits
// for downstream rounding. Input register plus five shift stages (16,8,4,2,1)
// with bubble-collapsing valid/ready flow control; latency 6, 1 beat/cycle.
//   clk, reset           clock, synchronous active-high reset
//   i_valid / o_ready    input handshake
//   i_data, i_cnt        mantissa and right-shift count (0..127)
//   o_valid / i_ready    output handshake
//   o_data               i_data >> min(i_cnt, WIDTH), zero fill
//   o_guard, o_sticky    last bit shifted out / OR of the bits below it
// ---------------------------------------------------------------------------
module denorm_shift
    import raybox_fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [LZC_CNT_W-1:0] i_cnt,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_guard,
    output logic                 o_sticky
);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_width_check
        $error("denorm_shift: WIDTH=%0d outside legal range 1..32", WIDTH);
    end

    localparam logic [LZC_CNT_W-1:0] WIDTH_CNT = LZC_CNT_W'(WIDTH);
    localparam logic [FX_MAX_W-1:0]  BELOW_MSB_M32 = low_ones(WIDTH - 1);
    localparam logic [WIDTH-1:0]     BELOW_MSB = BELOW_MSB_M32[WIDTH-1:0];

    // Index 0 is the input register, index k the output of shift stage k.
    logic                    vld_s [DENORM_STAGES+1];
    logic                    rdy_s [DENORM_STAGES+2];
    logic [WIDTH-1:0]        data_s[DENORM_STAGES+1];
    logic [DENORM_CNT_W-1:0] cnt_s [DENORM_STAGES+1];
    logic                    grd_s [DENORM_STAGES+1];
    logic                    stk_s [DENORM_STAGES+1];

    logic                    s0_valid_q;
    logic [WIDTH-1:0]        s0_data_q,   s0_data_d;
    logic [DENORM_CNT_W-1:0] s0_cnt_q,    s0_cnt_d;
    logic                    s0_guard_q,  s0_guard_d;
    logic                    s0_sticky_q, s0_sticky_d;

    // A count of WIDTH or more empties the mantissa completely. Such beats are
    // resolved here and sent down with a zero count: a clamp of 32 could not
    // be expressed by the 16..1 ladder, and resolving all clamps up front keeps
    // the shift stages free of the case.
    always_comb begin
        s0_data_d   = i_data;
        s0_cnt_d    = i_cnt[DENORM_CNT_W-1:0];
        s0_guard_d  = 1'b0;
        s0_sticky_d = 1'b0;
        if (i_cnt > WIDTH_CNT) begin
            s0_data_d   = '0;
            s0_cnt_d    = '0;
            s0_sticky_d = |i_data;
        end else if (i_cnt == WIDTH_CNT) begin
            s0_data_d   = '0;
            s0_cnt_d    = '0;
            s0_guard_d  = i_data[WIDTH-1];
            s0_sticky_d = |(i_data & BELOW_MSB);
        end
    end

    assign rdy_s[DENORM_STAGES+1] = i_ready;
    assign rdy_s[0]               = ~s0_valid_q | rdy_s[1];
    assign o_ready                = rdy_s[0];

    // ---- stage 0: clamp / input register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q  <= 1'b0;
            s0_data_q   <= '0;
            s0_cnt_q    <= '0;
            s0_guard_q  <= 1'b0;
            s0_sticky_q <= 1'b0;
        end else if (rdy_s[0]) begin
            s0_valid_q <= i_valid;
            if (i_valid) begin
                s0_data_q   <= s0_data_d;
                s0_cnt_q    <= s0_cnt_d;
                s0_guard_q  <= s0_guard_d;
                s0_sticky_q <= s0_sticky_d;
            end
        end
    end

    assign vld_s[0]  = s0_valid_q;
    assign data_s[0] = s0_data_q;
    assign cnt_s[0]  = s0_cnt_q;
    assign grd_s[0]  = s0_guard_q;
    assign stk_s[0]  = s0_sticky_q;

    // ---- stages 1..5: conditional shift by 16, 8, 4, 2, 1 ----
    for (genvar k = 1; k <= DENORM_STAGES; k++) begin : g_stage
        denorm_stage #(
            .WIDTH (WIDTH),
            .SHIFT (denorm_shift_amt(k - 1))
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .up_valid_i  (vld_s[k-1]),
            .up_ready_o  (rdy_s[k]),
            .up_data_i   (data_s[k-1]),
            .up_cnt_i    (cnt_s[k-1]),
            .up_guard_i  (grd_s[k-1]),
            .up_sticky_i (stk_s[k-1]),
            .dn_valid_o  (vld_s[k]),
            .dn_ready_i  (rdy_s[k+1]),
            .dn_data_o   (data_s[k]),
            .dn_cnt_o    (cnt_s[k]),
            .dn_guard_o  (grd_s[k]),
            .dn_sticky_o (stk_s[k])
        );
    end

    // The count is fully consumed by the last stage.
    logic unused_cnt;
    assign unused_cnt = ^cnt_s[DENORM_STAGES];

    assign o_valid  = vld_s[DENORM_STAGES];
    assign o_data   = data_s[DENORM_STAGES];
    assign o_guard  = grd_s[DENORM_STAGES];
    assign o_sticky = stk_s[DENORM_STAGES];

endmodule
